// File: rtl/stream_demux_pkg.sv
// Shared constants for the 1-to-2 stream demultiplexer: channel encodings,
// default geometry and the width of the optional delivered-beat counters.
package demux_pkg;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int DEF_WIDTH = 2;
    localparam int DEF_DEPTH = 2;

    localparam int COUNT_W = 16;

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle of the stream demultiplexer: one tagged input stream and
// two independent output streams (A and B) with valid/ready flow control.
interface stream_demux_if
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             In_valid;
    logic             In_ready;
    logic             Select;
    logic [WIDTH-1:0] Din;

    logic [WIDTH-1:0] A_out;
    logic             A_valid;
    logic             A_ready;

    logic [WIDTH-1:0] B_out;
    logic             B_valid;
    logic             B_ready;

    // Producer of Din and consumer of both channels.
    modport master (
        output In_valid, Select, Din, A_ready, B_ready,
        input  In_ready, A_out, A_valid, B_out, B_valid
    );

    modport slave (
        input  In_valid, Select, Din, A_ready, B_ready,
        output In_ready, A_out, A_valid, B_out, B_valid
    );

endinterface

// File: rtl/stream_demux_fifo.sv
// Per-channel synchronous FIFO with power-of-two depth; the head output holds
// the last popped entry while empty (zero after reset).
module demux_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic [WIDTH-1:0] r_last;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_occ == OCC_FULL);
    assign o_empty = (r_occ == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];

    // Storage carries data only; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_ONE;
                2'b01:   r_occ <= r_occ - OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: rtl/stream_demux.sv
// 1-to-2 stream demultiplexer: steers Select-tagged beats into per-channel FIFOs.
// Optional feature macro STREAM_DEMUX_CNT_EN adds 16-bit delivered-beat counters.
module stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_demux_if.slave      bus
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [COUNT_W-1:0] A_count,
    output logic [COUNT_W-1:0] B_count
`endif
);
    logic w_full_a, w_full_b;
    logic w_empty_a, w_empty_b;
    logic w_push_a, w_push_b;
    logic w_pop_a, w_pop_b;
    logic r_rdy_en;

    // Keeps In_ready low through reset and until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    assign bus.In_ready = r_rdy_en &&
                          ((bus.Select == CH_B) ? !w_full_b : !w_full_a);

    assign w_push_a = bus.In_valid && bus.In_ready && (bus.Select == CH_A);
    assign w_push_b = bus.In_valid && bus.In_ready && (bus.Select == CH_B);
    assign w_pop_a  = bus.A_ready && !w_empty_a;
    assign w_pop_b  = bus.B_ready && !w_empty_b;

    assign bus.A_valid = !w_empty_a;
    assign bus.B_valid = !w_empty_b;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_a),
        .i_din   (bus.Din),
        .i_pop   (w_pop_a),
        .o_full  (w_full_a),
        .o_empty (w_empty_a),
        .o_head  (bus.A_out)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push_b),
        .i_din   (bus.Din),
        .i_pop   (w_pop_b),
        .o_full  (w_full_b),
        .o_empty (w_empty_b),
        .o_head  (bus.B_out)
    );

`ifdef STREAM_DEMUX_CNT_EN
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic [COUNT_W-1:0] r_a_count;
    logic [COUNT_W-1:0] r_b_count;

    // Counts wrap naturally at 0xFFFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_pop_a) r_a_count <= r_a_count + CNT_ONE;
            if (w_pop_b) r_b_count <= r_b_count + CNT_ONE;
        end
    end

    assign A_count = r_a_count;
    assign B_count = r_b_count;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux: accepted beats are queued per channel and
// checked in order on every pop; scenario tasks add targeted inline checks.
module tb_stream_demux;
    import demux_pkg::*;

    localparam int W = 2;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    stream_demux_if #(.WIDTH(W)) bif ();

`ifdef STREAM_DEMUX_CNT_EN
    logic [COUNT_W-1:0] a_cnt;
    logic [COUNT_W-1:0] b_cnt;
`endif

    stream_demux #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .A_count (a_cnt),
        .B_count (b_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int b_pops = 0;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    // Scoreboard monitor: inputs change just after posedge, so negedge sees a stable cycle.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (rst_n) begin
            if (bif.A_valid && bif.A_ready) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL a_pop_unexpected got=%0h exp=<empty queue>", bif.A_out);
                end else begin
                    exp_v = qa.pop_front();
                    if (bif.A_out !== exp_v) begin
                        n_err++;
                        $display("FAIL a_pop_data got=%0h exp=%0h", bif.A_out, exp_v);
                    end
                end
            end
            if (bif.B_valid && bif.B_ready) begin
                n_cmp++;
                b_pops++;
                if (qb.size() == 0) begin
                    n_err++;
                    $display("FAIL b_pop_unexpected got=%0h exp=<empty queue>", bif.B_out);
                end else begin
                    exp_v = qb.pop_front();
                    if (bif.B_out !== exp_v) begin
                        n_err++;
                        $display("FAIL b_pop_data got=%0h exp=%0h", bif.B_out, exp_v);
                    end
                end
            end
            if (bif.In_valid && bif.In_ready) begin
                if (bif.Select == CH_B) qb.push_back(bif.Din);
                else                    qa.push_back(bif.Din);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        cyc();
        bif.In_valid = 1'b0;
        bif.A_ready  = 1'b1;
        bif.B_ready  = 1'b1;
        repeat (2 * D + 2) cyc();
        bif.A_ready = 1'b0;
        bif.B_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bif.In_valid = 1'b1;
        bif.Select   = CH_A;
        bif.Din      = 2'b11;
        bif.A_ready  = 1'b0;
        bif.B_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bif.In_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b exp=0", bif.In_ready); end
        n_cmp++; if (bif.A_valid !== 1'b0) begin n_err++; $display("FAIL rst_a_valid got=%b exp=0", bif.A_valid); end
        n_cmp++; if (bif.B_valid !== 1'b0) begin n_err++; $display("FAIL rst_b_valid got=%b exp=0", bif.B_valid); end
        n_cmp++; if (bif.A_out !== 2'b00) begin n_err++; $display("FAIL rst_a_out got=%0h exp=0", bif.A_out); end
        n_cmp++; if (bif.B_out !== 2'b00) begin n_err++; $display("FAIL rst_b_out got=%0h exp=0", bif.B_out); end
        cyc();
        rst_n        = 1'b1;
        bif.In_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.In_ready !== 1'b0) begin n_err++; $display("FAIL rel_in_ready_early got=%b exp=0", bif.In_ready); end
        cyc();
        @(negedge clk);
        n_cmp++; if (bif.In_ready !== 1'b1) begin n_err++; $display("FAIL rel_in_ready got=%b exp=1", bif.In_ready); end
    endtask

    task automatic test_steering();
        cyc();
        bif.A_ready  = 1'b0;
        bif.B_ready  = 1'b0;
        bif.In_valid = 1'b1;
        bif.Select   = CH_A;
        bif.Din      = 2'b01;
        cyc();
        bif.Select   = CH_B;
        bif.Din      = 2'b10;
        cyc();
        bif.In_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.A_valid !== 1'b1) begin n_err++; $display("FAIL steer_a_valid got=%b exp=1", bif.A_valid); end
        n_cmp++; if (bif.A_out !== 2'b01) begin n_err++; $display("FAIL steer_a_out got=%0h exp=1", bif.A_out); end
        n_cmp++; if (bif.B_valid !== 1'b1) begin n_err++; $display("FAIL steer_b_valid got=%b exp=1", bif.B_valid); end
        n_cmp++; if (bif.B_out !== 2'b10) begin n_err++; $display("FAIL steer_b_out got=%0h exp=2", bif.B_out); end
        drain();
    endtask

    task automatic test_full();
        logic [W-1:0] dv;
        logic         exp_rdy;
        cyc();
        bif.A_ready  = 1'b0;
        bif.B_ready  = 1'b0;
        bif.In_valid = 1'b1;
        bif.Select   = CH_A;
        for (int i = 0; i < 3; i++) begin
            dv      = W'(i + 1);
            bif.Din = dv;
            exp_rdy = (i < D);
            @(negedge clk);
            n_cmp++;
            if (bif.In_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL full_in_ready beat=%0d got=%b exp=%b", i, bif.In_ready, exp_rdy);
            end
            cyc();
        end
        bif.Select = CH_B;
        bif.Din    = 2'b00;
        @(negedge clk);
        n_cmp++; if (bif.In_ready !== 1'b1) begin n_err++; $display("FAIL full_b_accept got=%b exp=1", bif.In_ready); end
        cyc();
        bif.In_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.A_out !== 2'b01) begin n_err++; $display("FAIL full_a_head got=%0h exp=1", bif.A_out); end
    endtask

    task automatic test_simultaneous();
        cyc();
        bif.In_valid = 1'b1;
        bif.Select   = CH_A;
        bif.Din      = 2'b11;
        bif.A_ready  = 1'b1;
        @(negedge clk);
        n_cmp++; if (bif.In_ready !== 1'b0) begin n_err++; $display("FAIL sim_full_refuse got=%b exp=0", bif.In_ready); end
        cyc();
        @(negedge clk);
        n_cmp++; if (bif.In_ready !== 1'b1) begin n_err++; $display("FAIL sim_in_ready got=%b exp=1", bif.In_ready); end
        n_cmp++; if (bif.A_out !== 2'b10) begin n_err++; $display("FAIL sim_a_head got=%0h exp=2", bif.A_out); end
        cyc();
        bif.In_valid = 1'b0;
        bif.A_ready  = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.A_valid !== 1'b1) begin n_err++; $display("FAIL sim_a_valid got=%b exp=1", bif.A_valid); end
        n_cmp++; if (bif.A_out !== 2'b11) begin n_err++; $display("FAIL sim_a_out got=%0h exp=3", bif.A_out); end
        cyc();
        bif.A_ready = 1'b1;
        cyc();
        bif.A_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (bif.A_valid !== 1'b0) begin n_err++; $display("FAIL sim_occ_one got=%b exp=0", bif.A_valid); end
        n_cmp++; if (bif.A_out !== 2'b11) begin n_err++; $display("FAIL sim_hold_last got=%0h exp=3", bif.A_out); end
        drain();
    endtask

    task automatic test_order_wrap();
        logic [W-1:0] vals [6];
        int           idx;
        int           pops0;
        logic         acc;
        vals  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        idx   = 0;
        pops0 = b_pops;
        cyc();
        bif.A_ready = 1'b0;
        bif.Select  = CH_B;
        for (int g = 0; g < 40 && idx < 6; g++) begin
            bif.In_valid = 1'b1;
            bif.Din      = vals[idx];
            bif.B_ready  = (g % 2 == 0);
            @(negedge clk);
            acc = bif.In_ready;
            cyc();
            if (acc) idx++;
        end
        bif.In_valid = 1'b0;
        drain();
        @(negedge clk);
        n_cmp++; if (idx !== 6) begin n_err++; $display("FAIL order_accepted got=%0d exp=6", idx); end
        n_cmp++; if (b_pops - pops0 !== 6) begin n_err++; $display("FAIL order_delivered got=%0d exp=6", b_pops - pops0); end
        n_cmp++; if (qb.size() !== 0) begin n_err++; $display("FAIL order_leftover got=%0d exp=0", qb.size()); end
    endtask

    task automatic test_async_reset();
        cyc();
        bif.A_ready  = 1'b0;
        bif.B_ready  = 1'b0;
        bif.In_valid = 1'b1;
        bif.Select   = CH_A;
        bif.Din      = 2'b10;
        cyc();
        bif.Select   = CH_B;
        bif.Din      = 2'b01;
        cyc();
        bif.In_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bif.A_valid, bif.B_valid} !== 2'b11) begin n_err++; $display("FAIL ar_prefill got=%b exp=11", {bif.A_valid, bif.B_valid}); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bif.A_valid !== 1'b0) begin n_err++; $display("FAIL ar_a_valid_async got=%b exp=0", bif.A_valid); end
        n_cmp++; if (bif.B_valid !== 1'b0) begin n_err++; $display("FAIL ar_b_valid_async got=%b exp=0", bif.B_valid); end
        n_cmp++; if (bif.A_out !== 2'b00) begin n_err++; $display("FAIL ar_a_out got=%0h exp=0", bif.A_out); end
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        n_cmp++; if ({bif.A_valid, bif.B_valid} !== 2'b00) begin n_err++; $display("FAIL ar_empty got=%b exp=00", {bif.A_valid, bif.B_valid}); end
`ifdef STREAM_DEMUX_CNT_EN
        n_cmp++; if (a_cnt !== 16'h0000) begin n_err++; $display("FAIL ar_a_count got=%0h exp=0", a_cnt); end
        n_cmp++; if (b_cnt !== 16'h0000) begin n_err++; $display("FAIL ar_b_count got=%0h exp=0", b_cnt); end
`endif
        cyc();
        bif.A_ready  = 1'b1;
        bif.In_valid = 1'b1;
        bif.Select   = CH_A;
        for (int i = 0; i < 3; i++) begin
            bif.Din = W'(i);
            cyc();
        end
        bif.In_valid = 1'b0;
        repeat (2) cyc();
        bif.A_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (qa.size() !== 0) begin n_err++; $display("FAIL ar_a_drained got=%0d exp=0", qa.size()); end
`ifdef STREAM_DEMUX_CNT_EN
        n_cmp++; if (a_cnt !== 16'h0003) begin n_err++; $display("FAIL ar_a_count3 got=%0h exp=3", a_cnt); end
        n_cmp++; if (b_cnt !== 16'h0000) begin n_err++; $display("FAIL ar_b_count_idle got=%0h exp=0", b_cnt); end
`endif
    endtask

    initial begin
        bif.In_valid = 1'b0;
        bif.Select   = CH_A;
        bif.Din      = '0;
        bif.A_ready  = 1'b0;
        bif.B_ready  = 1'b0;
        test_reset();
        test_steering();
        test_full();
        test_simultaneous();
        test_order_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached compared=%0d mismatched=%0d", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule
